// File: rtl/chan_mux_reg.sv
// N-channel registered channel selector with per-channel valid/ready and a 1-entry output register.
// Optional round-robin scan mode compiled in with `define CHAN_MUX_RR_EN.
module chan_mux_reg #(
  parameter int N     = 10,
  parameter int W     = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [SEL_W-1:0] sel,
`ifdef CHAN_MUX_RR_EN
  input  logic             mode,
`endif
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_chan
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  logic             accept;
  logic             grant_ok;
  logic [SEL_W-1:0] gidx;
  logic [W-1:0]     gdata;
  logic             xfer_in;

  assign accept = !out_valid || out_ready;

`ifdef CHAN_MUX_RR_EN
  logic [SEL_W-1:0] rr_ptr;
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W:0]   cand;

  // Scan N slots starting at rr_ptr, wrapping modulo N; first valid channel wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, rr_ptr} + (SEL_W+1)'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!rr_found && in_valid[cand[SEL_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    if (mode) begin
      grant_ok = rr_found;
      gidx     = rr_idx;
    end else begin
      grant_ok = ({1'b0, sel} < N_EXT);
      gidx     = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (mode && xfer_in) begin
      rr_ptr <= ({1'b0, gidx} == N_EXT - 1'b1) ? '0 : gidx + 1'b1;
    end
  end
`else
  always_comb begin
    grant_ok = ({1'b0, sel} < N_EXT);
    gidx     = sel;
  end
`endif

  always_comb begin
    in_ready = '0;
    gdata    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gidx == SEL_W'(i)) begin
        in_ready[i] = accept && grant_ok && !rst;
        gdata       = in_data[i*W +: W];
      end
    end
  end

  assign xfer_in = |(in_ready & in_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      out_data  <= gdata;
      out_chan  <= gidx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chan_mux_reg.sv
// Directed self-checking bench for chan_mux_reg; round-robin scenarios run when CHAN_MUX_RR_EN is defined.
module tb_chan_mux_reg;

  localparam int N     = 10;
  localparam int W     = 16;
  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [SEL_W-1:0] sel;
  logic             mode;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] out_chan;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] d [N];

  always #5 clk = ~clk;

  chan_mux_reg #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
`ifdef CHAN_MUX_RR_EN
    .mode      (mode),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = '1; out_ready = 1'b1; sel = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", out_data); end
    checks++;
    if (out_chan !== 4'd0) begin failures++; $display("FAIL reset_chan got=%0d exp=0", out_chan); end
    checks++;
    if (in_ready !== '0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fixed_sweep();
    for (int s = 0; s < N; s++) begin
      @(negedge clk);
      sel = SEL_W'(s);
      #1;
      checks++;
      if (in_ready !== onehot(s)) begin failures++; $display("FAIL sweep_ready sel=%0d got=%b exp=%b", s, in_ready, onehot(s)); end
      @(posedge clk); #1;
      checks++;
      if (out_data !== d[s] || out_chan !== SEL_W'(s) || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL sweep_out sel=%0d got data=%h chan=%0d v=%b exp data=%h chan=%0d v=1", s, out_data, out_chan, out_valid, d[s], s);
      end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    sel = 4'd3; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_data !== 16'h000D) begin failures++; $display("FAIL stall_load got=%h exp=000D", out_data); end
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (in_ready !== '0) begin failures++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", c, in_ready); end
      @(posedge clk); #1;
      checks++;
      if (out_data !== 16'h000D || out_valid !== 1'b1 || out_chan !== 4'd3) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got data=%h v=%b chan=%0d exp 000D 1 3", c, out_data, out_valid, out_chan);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== onehot(3)) begin failures++; $display("FAIL stall_release_ready got=%b exp=%b", in_ready, onehot(3)); end
    @(posedge clk); #1;
    checks++;
    if (out_data !== 16'h000D || out_valid !== 1'b1) begin
      failures++; $display("FAIL stall_reload got data=%h v=%b exp 000D 1", out_data, out_valid);
    end
  endtask

  task automatic test_sel_out_of_range();
    @(negedge clk);
    sel = 4'hB; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== '0) begin failures++; $display("FAIL oor_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL oor_drain got v=%b exp=0", out_valid); end
    checks++;
    if (out_data !== 16'h000D) begin failures++; $display("FAIL oor_hold got=%h exp=000D", out_data); end
    @(negedge clk);
    sel = 4'd0;
    @(posedge clk); #1;
    checks++;
    if (out_data !== 16'h000A || out_chan !== 4'd0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL oor_recover got data=%h chan=%0d v=%b exp 000A 0 1", out_data, out_chan, out_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [5];
    exp_seq = '{2, 5, 9, 2, 5};
    @(negedge clk);
    mode = 1'b1; out_ready = 1'b1;
    in_valid = onehot(2) | onehot(5) | onehot(9);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_ready !== onehot(exp_seq[k])) begin
        failures++; $display("FAIL rr_ready step=%0d got=%b exp=%b", k, in_ready, onehot(exp_seq[k]));
      end
      @(posedge clk); #1;
      checks++;
      if (out_chan !== SEL_W'(exp_seq[k]) || out_data !== d[exp_seq[k]] || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL rr_grant step=%0d got chan=%0d data=%h exp chan=%0d data=%h", k, out_chan, out_data, exp_seq[k], d[exp_seq[k]]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== '0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_chan !== 4'd0) begin
      failures++; $display("FAIL mid_rst_out got v=%b data=%h chan=%0d exp 0 0000 0", out_valid, out_data, out_chan);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
`ifdef CHAN_MUX_RR_EN
    mode = 1'b1;
    in_valid = onehot(2) | onehot(5) | onehot(9);
    @(posedge clk); #1;
    checks++;
    if (out_chan !== 4'd2 || out_data !== 16'h000C) begin
      failures++; $display("FAIL mid_rr_first got chan=%0d data=%h exp 2 000C", out_chan, out_data);
    end
`else
    sel = 4'd7; in_valid = '1;
    @(posedge clk); #1;
    checks++;
    if (out_chan !== 4'd7 || out_data !== 16'h0002) begin
      failures++; $display("FAIL mid_first got chan=%0d data=%h exp 7 0002", out_chan, out_data);
    end
`endif
  endtask

  initial begin
    d = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E,
          16'h000F, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    for (int i = 0; i < N; i++) in_data[i*W +: W] = d[i];
    test_reset();
    test_fixed_sweep();
    test_stall();
    test_sel_out_of_range();
`ifdef CHAN_MUX_RR_EN
    test_round_robin();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
